instruction_loader: RTL

Boot-time controller for the instruction memory write port. After reset it owns the port and assembles bytes from the UART receiver into 32-bit words. It writes those words to consecutive instruction-memory addresses while holding the CPU in stall. On a terminator word it releases the CPU and hands the port to the CPU's store-to-instruction-memory path (the instruction writer outputs), which it forwards for the rest of operation.

---
 rtl/instruction_loader_pkg.sv | 6 +
 rtl/instruction_loader_if.sv | 23 ++
 rtl/instruction_loader_word_assembler.sv | 44 ++++
 rtl/instruction_loader.sv | 74 +++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: shared state type and constants for the boot-time instruction loader
package instruction_loader_pkg;
  typedef enum logic {LOAD, RUN} state_t;
  localparam int BCNT_W = 2;
  localparam logic [31:0] TERMINATOR_DEFAULT = 32'hFFFF_FFFF;
endpackage

// File: rtl/instruction_loader_if.sv
// instruction_loader_if: UART byte input, CPU store path and instruction-memory write port
interface instruction_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cpu_write_enable;
  logic [15:0] cpu_address;
  logic [31:0] cpu_write_data;
  logic        mem_write_enable;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic        cpu_stall;
  logic        load_done;
  logic [15:0] word_count;
  logic        overflow;
  modport master (
    output rx_valid, rx_data, cpu_write_enable, cpu_address, cpu_write_data,
    input  mem_write_enable, mem_address, mem_write_data, cpu_stall, load_done, word_count, overflow
  );
  modport slave (
    input  rx_valid, rx_data, cpu_write_enable, cpu_address, cpu_write_data,
    output mem_write_enable, mem_address, mem_write_data, cpu_stall, load_done, word_count, overflow
  );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// word_assembler: packs UART bytes big-endian into 32-bit words, discarding a stalled partial word
module word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_word_valid,
  output logic [31:0] o_word
);
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [23:0]       r_shift;
  logic [BCNT_W-1:0] r_bcnt;
  logic [IW-1:0]     r_idle;
  logic              w_rx;
  logic              w_idle;
  logic              w_expire;
  always_comb begin
    w_rx         = i_en & i_valid;
    w_idle       = i_en & ~i_valid & (r_bcnt != '0);
    w_expire     = w_idle & (r_idle == IW'(TIMEOUT - 1));
    o_word_valid = w_rx & (r_bcnt == BCNT_W'(3));
    o_word       = {r_shift, i_data};
  end
  // the shift register needs no clear: three new bytes fully overwrite any stale partial word
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_shift <= '0;
      r_bcnt  <= '0;
      r_idle  <= '0;
    end else if (w_rx) begin
      r_shift <= {r_shift[15:0], i_data};
      r_bcnt  <= r_bcnt + 1'b1;
      r_idle  <= '0;
    end else if (w_expire) begin
      r_bcnt  <= '0;
      r_idle  <= '0;
    end else if (w_idle)
      r_idle  <= r_idle + 1'b1;
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: owns the instruction-memory port at boot, then hands it to the CPU store path
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE  = 16'h0000,
  parameter int          DEPTH      = 16384,
  parameter logic [31:0] TERMINATOR = TERMINATOR_DEFAULT,
  parameter int          TIMEOUT    = 1_000_000
) (
  input logic                 clk,
  input logic                 reset,
  instruction_loader_if.slave bus
);
  state_t      r_state;
  state_t      w_next;
  logic        w_word_valid;
  logic [31:0] w_word;
  logic        w_term;
  logic        w_room;
  logic        w_wr;
  logic        r_we;
  logic [15:0] r_addr;
  logic [31:0] r_data;
  logic [15:0] r_count;
  logic        r_ovf;
  word_assembler #(.TIMEOUT(TIMEOUT)) u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_en         (r_state == LOAD),
    .i_valid      (bus.rx_valid),
    .i_data       (bus.rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= LOAD;
    else       r_state <= w_next;
  always_comb begin
    w_term = w_word_valid & (w_word == TERMINATOR);
    w_room = 32'(r_count) < 32'(DEPTH);
    w_wr   = w_word_valid & ~w_term & w_room;
    w_next = (r_state == LOAD && w_term) ? RUN : r_state;
  end
  // in RUN the port registers simply mirror the CPU store path with one cycle of latency
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (r_state == RUN) begin
      r_we    <= bus.cpu_write_enable;
      r_addr  <= bus.cpu_address;
      r_data  <= bus.cpu_write_data;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_addr  <= ADDR_BASE + r_count;
        r_data  <= w_word;
        r_count <= r_count + 1'b1;
      end
      if (w_word_valid & ~w_term & ~w_room) r_ovf <= 1'b1;
    end
  always_comb begin
    bus.cpu_stall        = r_state == LOAD;
    bus.load_done        = r_state == RUN;
    bus.mem_write_enable = r_we;
    bus.mem_address      = r_addr;
    bus.mem_write_data   = r_data;
    bus.word_count       = r_count;
    bus.overflow         = r_ovf;
  end
endmodule
